// File: rtl/clk_power_sequencer_pkg.sv
// Shared definitions for the CPU clock/power sequencer: state encoding and default timing.
package pwr_pkg;

    localparam int unsigned STATE_W           = 3;
    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned DEF_GATE_CYCLES   = 4;
    localparam int unsigned DEF_SETTLE_CYCLES = 1024;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN          = 3'd0,
        ST_HALT         = 3'd1,
        ST_STOP_GATE    = 3'd2,
        ST_STOP_OSC_OFF = 3'd3,
        ST_OSC_WAIT     = 3'd4
    } pwr_state_e;

endpackage

// File: rtl/clk_power_sequencer_if.sv
// Request/status bundle between decoder/interrupt logic, clock generator and the sequencer.
interface clk_power_sequencer_if;
    import pwr_pkg::*;

    logic               halt_req;
    logic               stop_req;
    logic               wake;
    logic               joypad_wake;
    logic               osc_stable;
    logic               sync_reset;
    logic               clk_ena;
    logic               osc_ena;
    logic               halted;
    logic               stopped;
    logic               div_reset;
    logic               halt_skip;
    logic [STATE_W-1:0] state;

    modport master (
        output halt_req, stop_req, wake, joypad_wake, osc_stable, sync_reset,
        input  clk_ena, osc_ena, halted, stopped, div_reset, halt_skip, state
    );

    modport slave (
        input  halt_req, stop_req, wake, joypad_wake, osc_stable, sync_reset,
        output clk_ena, osc_ena, halted, stopped, div_reset, halt_skip, state
    );

endinterface

// File: rtl/clk_power_sequencer_delay_counter.sv
// Loadable down-counter that saturates at zero; zero flag is registered alongside the count.
module pwr_delay_counter
    import pwr_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/clk_power_sequencer.sv
// HALT/STOP clock sequencer: gates CPU clock, stops/restarts the oscillator and sequences wake-up.
module clk_power_sequencer
    import pwr_pkg::*;
#(
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    clk_power_sequencer_if.slave  pwr_if
);

    pwr_state_e       state_q;
    pwr_state_e       state_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_value;
    logic             div_reset_d;
    logic             halt_skip_d;

    logic             clk_ena_q;
    logic             osc_ena_q;
    logic             halted_q;
    logic             stopped_q;
    logic             div_reset_q;
    logic             halt_skip_q;

    pwr_delay_counter #(
        .CNT_W (CNT_W)
    ) u_delay (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (cnt_load),
        .value_i (cnt_value),
        .dec_i   (cnt_dec),
        .zero_o  (cnt_zero)
    );

    // Next-state and counter control; sync_reset pulls straight back to RUN without a settle wait.
    always_comb begin
        state_d     = state_q;
        cnt_load    = 1'b0;
        cnt_value   = '0;
        cnt_dec     = 1'b0;
        div_reset_d = 1'b0;
        halt_skip_d = 1'b0;
        if (pwr_if.sync_reset) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pwr_if.stop_req) begin
                        state_d     = ST_STOP_GATE;
                        cnt_load    = 1'b1;
                        cnt_value   = CNT_W'(GATE_CYCLES - 1);
                        div_reset_d = 1'b1;
                    end else if (pwr_if.halt_req) begin
                        if (pwr_if.wake) begin
                            halt_skip_d = 1'b1;
                        end else begin
                            state_d = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    if (pwr_if.wake) begin
                        state_d = ST_RUN;
                    end
                end
                ST_STOP_GATE: begin
                    if (pwr_if.joypad_wake) begin
                        state_d = ST_RUN;
                    end else if (cnt_zero) begin
                        state_d = ST_STOP_OSC_OFF;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_STOP_OSC_OFF: begin
                    if (pwr_if.joypad_wake) begin
                        state_d   = ST_OSC_WAIT;
                        cnt_load  = 1'b1;
                        cnt_value = CNT_W'(SETTLE_CYCLES);
                    end
                end
                ST_OSC_WAIT: begin
                    // Wake is committed here: only settle time and oscillator stability matter.
                    if (cnt_zero && pwr_if.osc_stable) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_RUN;
            clk_ena_q   <= 1'b1;
            osc_ena_q   <= 1'b1;
            halted_q    <= 1'b0;
            stopped_q   <= 1'b0;
            div_reset_q <= 1'b0;
            halt_skip_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_ena_q   <= (state_d == ST_RUN);
            osc_ena_q   <= (state_d != ST_STOP_OSC_OFF);
            halted_q    <= (state_d == ST_HALT);
            stopped_q   <= (state_d == ST_STOP_GATE) || (state_d == ST_STOP_OSC_OFF)
                        || (state_d == ST_OSC_WAIT);
            div_reset_q <= div_reset_d;
            halt_skip_q <= halt_skip_d;
        end
    end

    assign pwr_if.clk_ena   = clk_ena_q;
    assign pwr_if.osc_ena   = osc_ena_q;
    assign pwr_if.halted    = halted_q;
    assign pwr_if.stopped   = stopped_q;
    assign pwr_if.div_reset = div_reset_q;
    assign pwr_if.halt_skip = halt_skip_q;
    assign pwr_if.state     = state_q;

endmodule
